// File: rtl/muller_c_bank_formal.sv
// Bank of 2-input Muller C-elements plus a tree C-element, a sticky self-check and a cover strobe.
// All outputs registered: io_in -> c_out is 1 clock, io_in -> c_all/cover_hit is 2 clocks.
module muller_c_bank_formal #(
  parameter int   NUM_PAIRS = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [2*NUM_PAIRS-1:0] io_in,
  output logic [NUM_PAIRS-1:0]   c_out,
  output logic                   c_all,
  output logic                   err,
  output logic                   cover_hit
);

  logic [NUM_PAIRS-1:0] a;
  logic [NUM_PAIRS-1:0] b;
  logic [NUM_PAIRS-1:0] c_next;
  logic                 all_next;

  // Shadow state for the self-check: inputs and outputs as seen at the previous edge.
  logic [NUM_PAIRS-1:0] dis_q;
  logic [NUM_PAIRS-1:0] c_prev;
  logic                 all_prev;
  logic                 c_bad;
  logic                 all_bad;

  always_comb begin
    a = '0;
    b = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      a[k] = io_in[2*k];
      b[k] = io_in[2*k+1];
    end
  end

  // Agreeing inputs force the state; disagreeing inputs keep it.
  assign c_next   = (a & b) | (c_out & (a ^ b));
  assign all_next = (&c_out) | (c_all & (|c_out));

  // An element may only move if the inputs that moved it agreed; the tree may only
  // move if the element outputs it sampled were unanimous.
  assign c_bad   = |((c_out ^ c_prev) & dis_q);
  assign all_bad = (c_all ^ all_prev) & ~((&c_prev) | ~(|c_prev));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      c_out     <= {NUM_PAIRS{RESET_VAL}};
      c_all     <= RESET_VAL;
      err       <= 1'b0;
      cover_hit <= 1'b0;
      dis_q     <= '0;
      c_prev    <= {NUM_PAIRS{RESET_VAL}};
      all_prev  <= RESET_VAL;
    end else begin
      c_out     <= c_next;
      c_all     <= all_next;
      cover_hit <= all_next & ~c_all;
      err       <= err | c_bad | all_bad;
      dis_q     <= a ^ b;
      c_prev    <= c_out;
      all_prev  <= c_all;
    end
  end

endmodule

// File: tb/tb_muller_c_bank_formal.sv
// Directed plus randomized bench for muller_c_bank_formal against a behavioural C-element model.
module tb_muller_c_bank_formal;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [5:0] io_in    = 6'b100010;
  logic [2:0] c_out;
  logic       c_all;
  logic       err;
  logic       cover_hit;

  int n_pass = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  muller_c_bank_formal #(.NUM_PAIRS(3), .RESET_VAL(1'b0)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .io_in    (io_in),
    .c_out    (c_out),
    .c_all    (c_all),
    .err      (err),
    .cover_hit(cover_hit)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural reference: each pair copies its value when both bits agree;
  // the rendezvous follows a unanimous vote of the previous element outputs.
  logic [2:0] m_c   = 3'b000;
  logic       m_all = 1'b0;
  logic       m_cov = 1'b0;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_c   = 3'b000;
      m_all = 1'b0;
      m_cov = 1'b0;
    end else begin
      logic [2:0] old_c;
      logic       old_all;
      int         ones;
      old_c   = m_c;
      old_all = m_all;
      ones    = int'(old_c[0]) + int'(old_c[1]) + int'(old_c[2]);
      for (int k = 0; k < 3; k++)
        if (io_in[2*k] == io_in[2*k+1]) m_c[k] = io_in[2*k];
      if (ones == 3) m_all = 1'b1;
      else if (ones == 0) m_all = 1'b0;
      m_cov = m_all && !old_all;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge wb_clk_i) begin
    if (run_cmp) begin
      chk("model c_out", 32'(c_out), 32'(m_c));
      chk("model c_all", 32'(c_all), 32'(m_all));
      chk("model cover_hit", 32'(cover_hit), 32'(m_cov));
      chk("model err", 32'(err), 32'(0));
    end
  end

  task automatic cyc(input logic [5:0] v);
    @(negedge wb_clk_i);
    io_in = v;
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    // Reset with disagreeing/zero pairs, then run three cycles.
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    run_cmp  = 1'b1;
    repeat (3) cyc(6'b100010);
    chk("reset c_out", 32'(c_out), 32'h0);
    chk("reset c_all", 32'(c_all), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset cover", 32'(cover_hit), 32'h0);

    // Set, hold, clear of element 0.
    cyc(6'b000011); chk("set pair0", 32'(c_out), 32'h1);
    chk("model pin set", 32'(m_c), 32'h1);
    cyc(6'b000010); chk("hold pair0", 32'(c_out), 32'h1);
    cyc(6'b000000); chk("clear pair0", 32'(c_out), 32'h0);

    // Full rendezvous and cover pulse.
    cyc(6'b111111); chk("all set c_out", 32'(c_out), 32'h7);
    chk("all set c_all lag", 32'(c_all), 32'h0);
    cyc(6'b111111); chk("rendezvous c_all", 32'(c_all), 32'h1);
    chk("cover pulse", 32'(cover_hit), 32'h1);
    chk("model pin cover", 32'(m_cov), 32'h1);
    cyc(6'b101010); chk("hold c_out", 32'(c_out), 32'h7);
    chk("hold c_all", 32'(c_all), 32'h1);
    chk("cover one cycle", 32'(cover_hit), 32'h0);

    // Partial release keeps the tree, full release drops it a cycle later.
    cyc(6'b000011); chk("partial c_out", 32'(c_out), 32'h1);
    chk("partial c_all", 32'(c_all), 32'h1);
    cyc(6'b000000); chk("release c_out", 32'(c_out), 32'h0);
    chk("release c_all hold", 32'(c_all), 32'h1);
    cyc(6'b000000); chk("release c_all", 32'(c_all), 32'h0);

    // Asynchronous reset between edges.
    cyc(6'b111111);
    cyc(6'b111111);
    chk("pre-reset c_all", 32'(c_all), 32'h1);
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("async rst c_out", 32'(c_out), 32'h0);
    chk("async rst c_all", 32'(c_all), 32'h0);
    chk("async rst err", 32'(err), 32'h0);
    repeat (2) cyc(6'b111111);
    chk("in-reset hold", 32'(c_out), 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("post-reset c_out", 32'(c_out), 32'h7);
    chk("post-reset c_all", 32'(c_all), 32'h0);

    // Randomized run, biased so pairs agree often enough to reach rendezvous.
    for (int i = 0; i < 10000; i++) begin
      logic [5:0] v;
      v = 6'($urandom);
      if ($urandom_range(0, 3) == 0) v = {3{v[1:0]}};
      if ($urandom_range(0, 7) == 0) v = {6{v[0]}};
      cyc(v);
    end
    @(negedge wb_clk_i);
    run_cmp = 1'b0;
    chk("final err", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
